// File: rtl/mdu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl_if
// Bundles every non-clock/reset signal of the MDU issue/writeback controller.
// Member names keep the controller's point of view (_i = into controller,
// _o = out of controller).
//   slave  modport : the controller itself (mdu_issue_ctrl)
//   master modport : the environment (decode + MDU + writeback consumer)
// Signals:
//   i_valid/o_ready             decode op handshake
//   i_op/i_rd/i_op1/i_op2       op, destination tag, operands
//   i_flush                     kill all ops in flight
//   i_rs1/i_rs2, o_hazard       RAW hazard query from decode
//   o_mdu_enable/op/op1/op2     issue port to the fixed-latency MDU
//   i_mdu_result                MDU result, valid LATENCY cycles after issue
//   o_wb_valid/o_wb_rd/o_wb_data single writeback port
//   o_busy                      any op in flight
// ---------------------------------------------------------------------------
interface mdu_issue_ctrl_if #(
  parameter int REG_WIDTH = 32,
  parameter int TAG_WIDTH = 5
);
  logic                 i_valid;
  logic                 o_ready;
  logic [2:0]           i_op;
  logic [TAG_WIDTH-1:0] i_rd;
  logic [REG_WIDTH-1:0] i_op1;
  logic [REG_WIDTH-1:0] i_op2;
  logic                 i_flush;
  logic [TAG_WIDTH-1:0] i_rs1;
  logic [TAG_WIDTH-1:0] i_rs2;
  logic                 o_hazard;
  logic                 o_mdu_enable;
  logic [2:0]           o_mdu_op;
  logic [REG_WIDTH-1:0] o_mdu_op1;
  logic [REG_WIDTH-1:0] o_mdu_op2;
  logic [REG_WIDTH-1:0] i_mdu_result;
  logic                 o_wb_valid;
  logic [TAG_WIDTH-1:0] o_wb_rd;
  logic [REG_WIDTH-1:0] o_wb_data;
  logic                 o_busy;

  modport slave (
    input  i_valid, i_op, i_rd, i_op1, i_op2, i_flush, i_rs1, i_rs2, i_mdu_result,
    output o_ready, o_hazard, o_mdu_enable, o_mdu_op, o_mdu_op1, o_mdu_op2,
           o_wb_valid, o_wb_rd, o_wb_data, o_busy
  );

  modport master (
    output i_valid, i_op, i_rd, i_op1, i_op2, i_flush, i_rs1, i_rs2, i_mdu_result,
    input  o_ready, o_hazard, o_mdu_enable, o_mdu_op, o_mdu_op1, o_mdu_op2,
           o_wb_valid, o_wb_rd, o_wb_data, o_busy
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
// Issue and writeback controller for a pipelined, fixed-latency multiply /
// divide unit. Accepts ops from decode, issues normal ops to the MDU, resolves
// RISC-V divide-by-zero and signed-overflow cases locally (fast path), tracks
// destination tags in flight, arbitrates the single writeback port and answers
// RAW hazard queries.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  mdu_issue_ctrl_if.slave (handshake, MDU port, writeback, hazard query)
// Parameters:
//   REG_WIDTH  operand/result width
//   LATENCY    MDU issue-to-result latency in cycles (>= 1)
//   TAG_WIDTH  destination register index width
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int REG_WIDTH = 32,
  parameter int LATENCY   = 5,
  parameter int TAG_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  mdu_issue_ctrl_if.slave   bus
);

  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  localparam logic [REG_WIDTH-1:0] ZERO_W   = {REG_WIDTH{1'b0}};
  localparam logic [REG_WIDTH-1:0] ALL_ONES = {REG_WIDTH{1'b1}};
  localparam logic [REG_WIDTH-1:0] INT_MIN  = {1'b1, {(REG_WIDTH-1){1'b0}}};
  localparam logic [TAG_WIDTH-1:0] ZERO_T   = {TAG_WIDTH{1'b0}};

  // Returns {is_fast, result}. Fast ops are the divide special cases whose
  // result is known without the MDU: x/0, x%0 and INT_MIN / -1 (signed only).
  function automatic logic [REG_WIDTH:0] fast_path(
    input logic [2:0]           op,
    input logic [REG_WIDTH-1:0] a,
    input logic [REG_WIDTH-1:0] b
  );
    logic [REG_WIDTH:0] res;
    logic               div0;
    logic               ovf;
    div0 = (b == ZERO_W);
    ovf  = (a == INT_MIN) && (b == ALL_ONES);
    case (op)
      OP_DIV: begin
        if (div0) begin
          res = {1'b1, ALL_ONES};
        end else if (ovf) begin
          res = {1'b1, INT_MIN};
        end else begin
          res = {1'b0, ZERO_W};
        end
      end
      OP_DIVU: res = div0 ? {1'b1, ALL_ONES} : {1'b0, ZERO_W};
      OP_REM: begin
        if (div0) begin
          res = {1'b1, a};
        end else if (ovf) begin
          res = {1'b1, ZERO_W};
        end else begin
          res = {1'b0, ZERO_W};
        end
      end
      OP_REMU: res = div0 ? {1'b1, a} : {1'b0, ZERO_W};
      default: res = {1'b0, ZERO_W};
    endcase
    return res;
  endfunction

  // Tag pipe: stage i holds the op issued i+1 cycles ago; the tail stage
  // lines up with the MDU result of that op.
  logic [LATENCY-1:0]   tag_vld_q, tag_vld_d;
  logic [TAG_WIDTH-1:0] tag_rd_q [LATENCY];
  logic [TAG_WIDTH-1:0] tag_rd_d [LATENCY];

  // One-entry buffer for fast-path results waiting for the writeback port.
  logic                 fbuf_vld_q, fbuf_vld_d;
  logic [TAG_WIDTH-1:0] fbuf_rd_q, fbuf_rd_d;
  logic [REG_WIDTH-1:0] fbuf_data_q, fbuf_data_d;

  // Writeback register.
  logic                 wb_vld_q, wb_vld_d;
  logic [TAG_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [REG_WIDTH-1:0] wb_data_q, wb_data_d;

  logic                 rd_nz_s;
  logic                 waw_hit_s;
  logic                 rs1_hit_s;
  logic                 rs2_hit_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 is_fast_s;
  logic [REG_WIDTH-1:0] fast_data_s;
  logic                 issue_s;
  logic                 fast_load_s;
  logic                 tail_vld_s;
  logic                 fbuf_drain_s;

  // Fast-path classification of the op presented by decode.
  always_comb begin
    {is_fast_s, fast_data_s} = fast_path(bus.i_op, bus.i_op1, bus.i_op2);
  end

  // Tag match against every pending writer: tag pipe, fast buffer, wb register.
  always_comb begin
    waw_hit_s = (fbuf_vld_q && (fbuf_rd_q == bus.i_rd)) ||
                (wb_vld_q   && (wb_rd_q   == bus.i_rd));
    rs1_hit_s = (fbuf_vld_q && (fbuf_rd_q == bus.i_rs1)) ||
                (wb_vld_q   && (wb_rd_q   == bus.i_rs1));
    rs2_hit_s = (fbuf_vld_q && (fbuf_rd_q == bus.i_rs2)) ||
                (wb_vld_q   && (wb_rd_q   == bus.i_rs2));
    for (int i = 0; i < LATENCY; i++) begin
      waw_hit_s = waw_hit_s | (tag_vld_q[i] && (tag_rd_q[i] == bus.i_rd));
      rs1_hit_s = rs1_hit_s | (tag_vld_q[i] && (tag_rd_q[i] == bus.i_rs1));
      rs2_hit_s = rs2_hit_s | (tag_vld_q[i] && (tag_rd_q[i] == bus.i_rs2));
    end
  end

  // Accept / issue decisions. Ready is also held low while rst is asserted so
  // that nothing can be issued from a controller whose state is being cleared.
  always_comb begin
    rd_nz_s     = (bus.i_rd != ZERO_T);
    ready_s     = !rst && !bus.i_flush && !fbuf_vld_q && !(rd_nz_s && waw_hit_s);
    accept_s    = bus.i_valid && ready_s;
    issue_s     = accept_s && !is_fast_s && rd_nz_s;
    fast_load_s = accept_s && is_fast_s && rd_nz_s;
    tail_vld_s  = tag_vld_q[LATENCY-1];
  end

  // Tag pipe next state: shift by one every cycle, flush clears all valids.
  always_comb begin
    tag_vld_d[0] = issue_s && !bus.i_flush;
    tag_rd_d[0]  = bus.i_rd;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1] && !bus.i_flush;
      tag_rd_d[i]  = tag_rd_q[i-1];
    end
  end

  // Writeback arbitration: an arriving MDU result always wins over the buffer.
  always_comb begin
    wb_vld_d     = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fbuf_drain_s = 1'b0;
    if (bus.i_flush) begin
      wb_vld_d = 1'b0;
    end else if (tail_vld_s) begin
      wb_vld_d  = 1'b1;
      wb_rd_d   = tag_rd_q[LATENCY-1];
      wb_data_d = bus.i_mdu_result;
    end else if (fbuf_vld_q) begin
      wb_vld_d     = 1'b1;
      wb_rd_d      = fbuf_rd_q;
      wb_data_d    = fbuf_data_q;
      fbuf_drain_s = 1'b1;
    end else begin
      wb_vld_d = 1'b0;
    end
  end

  // Fast buffer next state. A load can only happen when the buffer is empty,
  // since a full buffer holds o_ready low.
  always_comb begin
    fbuf_vld_d  = fbuf_vld_q;
    fbuf_rd_d   = fbuf_rd_q;
    fbuf_data_d = fbuf_data_q;
    if (bus.i_flush) begin
      fbuf_vld_d = 1'b0;
    end else if (fast_load_s) begin
      fbuf_vld_d  = 1'b1;
      fbuf_rd_d   = bus.i_rd;
      fbuf_data_d = fast_data_s;
    end else if (fbuf_drain_s) begin
      fbuf_vld_d = 1'b0;
    end else begin
      fbuf_vld_d = fbuf_vld_q;
    end
  end

  // Tag pipe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        tag_rd_q[i] <= ZERO_T;
      end
    end else begin
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_rd_q[i] <= tag_rd_d[i];
      end
    end
  end

  // Fast buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fbuf_vld_q  <= 1'b0;
      fbuf_rd_q   <= ZERO_T;
      fbuf_data_q <= ZERO_W;
    end else begin
      fbuf_vld_q  <= fbuf_vld_d;
      fbuf_rd_q   <= fbuf_rd_d;
      fbuf_data_q <= fbuf_data_d;
    end
  end

  // Writeback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= ZERO_T;
      wb_data_q <= ZERO_W;
    end else begin
      wb_vld_q  <= wb_vld_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Output drive. The hazard answer ignores the op being accepted this cycle.
  always_comb begin
    bus.o_ready      = ready_s;
    bus.o_mdu_enable = issue_s;
    bus.o_mdu_op     = bus.i_op;
    bus.o_mdu_op1    = bus.i_op1;
    bus.o_mdu_op2    = bus.i_op2;
    bus.o_hazard     = ((bus.i_rs1 != ZERO_T) && rs1_hit_s) ||
                       ((bus.i_rs2 != ZERO_T) && rs2_hit_s);
    bus.o_busy       = (|tag_vld_q) || fbuf_vld_q || wb_vld_q;
    bus.o_wb_valid   = wb_vld_q;
    bus.o_wb_rd      = wb_rd_q;
    bus.o_wb_data    = wb_data_q;
  end

endmodule
